multicycle_control: RTL and testbench

- Sequencing controller for a multi-cycle LEGv8 datapath. The existing single-cycle datapath is split into fetch/decode/execute/memory/writeback steps, with instruction and data memory shared behind one handshaked memory port.
- The block drives all datapath strobes and retires one instruction per 3–5+ cycles.
- It owns a memory-wait timeout, an illegal-opcode halt and a retired-instruction counter.

---
 rtl/multicycle_control.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Sequencing controller for a multi-cycle LEGv8 datapath: drives the datapath
// strobes per step, times out stalled memory requests and counts retirements.
module multicycle_control #(
  parameter int COUNT_WIDTH = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [10:0]            opcode,
  input  logic                   zero_alu,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_source,
  output logic                   ir_write,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   mem_is_fetch,
  output logic                   reg_write,
  output logic                   reg_to_loc,
  output logic                   alu_src,
  output logic                   mem_to_reg,
  output logic [1:0]             alu_op,
  output logic                   halted,
  output logic                   illegal_opcode,
  output logic                   bus_error,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_RTYPE, C_LDUR, C_STUR, C_CBZ, C_B
  } class_t;

  state_t          state_reg, state_next;
  class_t          class_reg, class_next, class_dec;
  logic [WW-1:0]   wait_reg, wait_next;
  logic            illegal_next, bus_error_next, retire;
  logic            timeout;

  // Exact encodings take priority over the masked CBZ and B patterns.
  always_comb begin
    class_dec = C_NONE;
    if (opcode == 11'b10001011000 || opcode == 11'b11001011000 ||
        opcode == 11'b10001010000 || opcode == 11'b10101010000)
      class_dec = C_RTYPE;
    else if (opcode == 11'b11111000010)
      class_dec = C_LDUR;
    else if (opcode == 11'b11111000000)
      class_dec = C_STUR;
    else if (opcode[10:3] == 8'b10110100)
      class_dec = C_CBZ;
    else if (opcode[10:5] == 6'b000101)
      class_dec = C_B;
  end

  assign timeout = !mem_ready && (wait_reg == WW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_next     = state_reg;
    class_next     = class_reg;
    wait_next      = '0;
    illegal_next   = illegal_opcode;
    bus_error_next = bus_error;
    retire         = 1'b0;
    pc_write       = 1'b0;
    pc_source      = 1'b0;
    ir_write       = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_is_fetch   = 1'b0;
    reg_write      = 1'b0;
    reg_to_loc     = 1'b0;
    alu_src        = 1'b0;
    mem_to_reg     = 1'b0;
    alu_op         = 2'b00;
    halted         = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          mem_read     = 1'b1;
          mem_is_fetch = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = S_DECODE;
          end else if (timeout) begin
            bus_error_next = 1'b1;
            state_next     = S_HALT;
          end else begin
            wait_next = wait_reg + 1'b1;
          end
        end
        S_DECODE: begin
          class_next = class_dec;
          reg_to_loc = (class_dec == C_STUR) || (class_dec == C_CBZ);
          if (class_dec == C_NONE) begin
            illegal_next = 1'b1;
            state_next   = S_HALT;
          end else begin
            state_next = S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          case (class_reg)
            C_RTYPE: begin
              alu_op     = 2'b10;
              state_next = S_WRITEBACK;
            end
            C_LDUR, C_STUR: begin
              alu_src    = 1'b1;
              reg_to_loc = (class_reg == C_STUR);
              state_next = S_MEMORY;
            end
            C_CBZ: begin
              reg_to_loc = 1'b1;
              alu_op     = 2'b01;
              pc_write   = zero_alu;
              pc_source  = zero_alu;
              retire     = 1'b1;
              state_next = S_FETCH;
            end
            C_B: begin
              pc_write   = 1'b1;
              pc_source  = 1'b1;
              retire     = 1'b1;
              state_next = S_FETCH;
            end
            default: state_next = S_HALT;
          endcase
        end
        S_MEMORY: begin
          alu_src    = 1'b1;
          mem_read   = (class_reg == C_LDUR);
          mem_write  = (class_reg == C_STUR);
          reg_to_loc = (class_reg == C_STUR);
          if (mem_ready) begin
            retire     = (class_reg == C_STUR);
            state_next = (class_reg == C_STUR) ? S_FETCH : S_WRITEBACK;
          end else if (timeout) begin
            bus_error_next = 1'b1;
            state_next     = S_HALT;
          end else begin
            wait_next = wait_reg + 1'b1;
          end
        end
        S_WRITEBACK: begin
          reg_write  = 1'b1;
          mem_to_reg = (class_reg == C_LDUR);
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        default: begin
          halted     = 1'b1;
          state_next = S_HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= S_FETCH;
      class_reg      <= C_NONE;
      wait_reg       <= '0;
      illegal_opcode <= 1'b0;
      bus_error      <= 1'b0;
      retired_count  <= '0;
    end else begin
      state_reg      <= state_next;
      class_reg      <= class_next;
      wait_reg       <= wait_next;
      illegal_opcode <= illegal_next;
      bus_error      <= bus_error_next;
      if (retire)
        retired_count <= retired_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle strobe vectors checked
// against hand-computed values with immediate assertions.
module tb_multicycle_control;

  logic        clock = 1'b0;
  logic        reset;
  logic [10:0] opcode;
  logic        zero_alu;
  logic        mem_ready;
  logic        pc_write, pc_source, ir_write, mem_read, mem_write, mem_is_fetch;
  logic        reg_write, reg_to_loc, alu_src, mem_to_reg;
  logic [1:0]  alu_op;
  logic        halted, illegal_opcode, bus_error;
  logic [31:0] retired_count;

  int errors = 0;
  int checks = 0;

  multicycle_control #(.COUNT_WIDTH(32), .MEM_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero_alu(zero_alu),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_source(pc_source),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_is_fetch(mem_is_fetch), .reg_write(reg_write), .reg_to_loc(reg_to_loc),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
    .halted(halted), .illegal_opcode(illegal_opcode), .bus_error(bus_error),
    .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  // {pc_write,pc_source,ir_write,mem_read | mem_write,mem_is_fetch,reg_write,reg_to_loc | alu_src,mem_to_reg,alu_op}
  wire [11:0] strobes = {pc_write, pc_source, ir_write, mem_read, mem_write, mem_is_fetch,
                         reg_write, reg_to_loc, alu_src, mem_to_reg, alu_op};

  localparam logic [11:0] NONE    = 12'b0000_0000_0000;
  localparam logic [11:0] F_RDY   = 12'b1011_0100_0000;
  localparam logic [11:0] F_WAIT  = 12'b0001_0100_0000;
  localparam logic [11:0] D_RLOC  = 12'b0000_0001_0000;
  localparam logic [11:0] E_R     = 12'b0000_0000_0010;
  localparam logic [11:0] E_LD    = 12'b0000_0000_1000;
  localparam logic [11:0] E_ST    = 12'b0000_0001_1000;
  localparam logic [11:0] E_CBZ_T = 12'b1100_0001_0001;
  localparam logic [11:0] E_CBZ_N = 12'b0000_0001_0001;
  localparam logic [11:0] E_B     = 12'b1100_0000_0000;
  localparam logic [11:0] M_LD    = 12'b0001_0000_1000;
  localparam logic [11:0] M_ST    = 12'b0000_1001_1000;
  localparam logic [11:0] W_R     = 12'b0000_0010_0000;
  localparam logic [11:0] W_LD    = 12'b0000_0010_0100;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010111111;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge: apply inputs, check strobes, advance one cycle.
  task automatic step(input logic rdy, input logic zr, input logic [10:0] opc,
                      input string tag, input logic [11:0] exp_strobes);
    mem_ready = rdy;
    zero_alu  = zr;
    opcode    = opc;
    #1;
    chk(tag, {20'd0, strobes}, {20'd0, exp_strobes});
    $display("step %-12s rdy=%b zero=%b op=%b strobes=%b count=%0d", tag, rdy, zr, opc, strobes, retired_count);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; opcode = OP_ADD; zero_alu = 1'b0; mem_ready = 1'b0;
    @(posedge clock); @(posedge clock); @(negedge clock);
    chk("rst_strobes", {20'd0, strobes}, 32'd0);
    chk("rst_count", retired_count, 32'd0);
    chk("rst_flags", {29'd0, halted, illegal_opcode, bus_error}, 32'd0);
    reset = 1'b0;

    step(1, 0, OP_ADD, "add_fetch", F_RDY);
    step(0, 0, OP_ADD, "add_decode", NONE);
    step(1, 0, OP_ADD, "add_exec", E_R);
    chk("add_count_pre", retired_count, 32'd0);
    step(1, 0, OP_ADD, "add_wb", W_R);
    chk("add_count", retired_count, 32'd1);

    step(1, 0, OP_LDUR, "ld_fetch", F_RDY);
    step(0, 0, OP_LDUR, "ld_decode", NONE);
    step(0, 0, OP_LDUR, "ld_exec", E_LD);
    for (int i = 0; i < 3; i++) step(0, 0, OP_LDUR, "ld_mem_wait", M_LD);
    step(1, 0, OP_LDUR, "ld_mem_done", M_LD);
    chk("ld_count_pre", retired_count, 32'd1);
    step(0, 0, OP_LDUR, "ld_wb", W_LD);
    chk("ld_count", retired_count, 32'd2);

    step(1, 0, OP_CBZ, "cbz1_fetch", F_RDY);
    step(0, 0, OP_CBZ, "cbz1_decode", D_RLOC);
    step(0, 1, OP_CBZ, "cbz1_exec", E_CBZ_T);
    chk("cbz1_count", retired_count, 32'd3);
    step(1, 1, OP_CBZ, "cbz0_fetch", F_RDY);
    step(0, 1, OP_CBZ, "cbz0_decode", D_RLOC);
    step(0, 0, OP_CBZ, "cbz0_exec", E_CBZ_N);
    chk("cbz0_count", retired_count, 32'd4);

    step(1, 0, OP_B, "b_fetch", F_RDY);
    step(0, 0, OP_B, "b_decode", NONE);
    step(0, 0, OP_B, "b_exec", E_B);
    chk("b_count", retired_count, 32'd5);

    step(1, 0, OP_STUR, "st_fetch", F_RDY);
    step(0, 0, OP_STUR, "st_decode", D_RLOC);
    step(0, 0, OP_STUR, "st_exec", E_ST);
    step(1, 0, OP_STUR, "st_mem", M_ST);
    chk("st_count", retired_count, 32'd6);
    step(1, 0, OP_BAD, "bad_fetch", F_RDY);
    step(1, 0, OP_BAD, "bad_decode", NONE);
    chk("bad_flags", {29'd0, halted, illegal_opcode, bus_error}, 32'b110);
    for (int i = 0; i < 3; i++) step(1, 1, OP_ADD, "halt_idle", NONE);
    chk("halt_count", retired_count, 32'd6);
    chk("halt_flags", {29'd0, halted, illegal_opcode, bus_error}, 32'b110);

    do_reset();
    chk("rst2_flags", {29'd0, halted, illegal_opcode, bus_error}, 32'd0);
    chk("rst2_count", retired_count, 32'd0);
    for (int i = 0; i < 14; i++) step(0, 0, OP_ADD, "to_wait", F_WAIT);
    chk("to_not_yet", {29'd0, halted, illegal_opcode, bus_error}, 32'd0);
    step(0, 0, OP_ADD, "to_last", F_WAIT);
    chk("to_flags", {29'd0, halted, illegal_opcode, bus_error}, 32'b101);
    step(1, 0, OP_ADD, "to_halt", NONE);

    do_reset();
    for (int i = 0; i < 14; i++) step(0, 0, OP_ADD, "edge_wait", F_WAIT);
    step(1, 0, OP_ADD, "edge_ready", F_RDY);
    step(0, 0, OP_ADD, "edge_decode", NONE);
    chk("edge_flags", {29'd0, halted, illegal_opcode, bus_error}, 32'd0);
    step(0, 0, OP_ADD, "edge_exec", E_R);
    step(0, 0, OP_ADD, "edge_wb", W_R);
    chk("edge_count", retired_count, 32'd1);

    step(1, 0, OP_LDUR, "rm_fetch", F_RDY);
    step(0, 0, OP_LDUR, "rm_decode", NONE);
    step(0, 0, OP_LDUR, "rm_exec", E_LD);
    step(0, 0, OP_LDUR, "rm_mem1", M_LD);
    step(0, 0, OP_LDUR, "rm_mem2", M_LD);
    reset = 1'b1;
    #1;
    chk("rm_in_reset", {20'd0, strobes}, 32'd0);
    @(posedge clock); @(negedge clock);
    chk("rm_after_strobes", {20'd0, strobes}, 32'd0);
    chk("rm_after_count", retired_count, 32'd0);
    reset = 1'b0;
    step(0, 0, OP_LDUR, "rm_refetch", F_WAIT);
    step(1, 0, OP_LDUR, "rm_refetch2", F_RDY);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
